// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 style memory controller slice.
//   - Memory-mapped device register addresses (keyboard, display, machine control).
//   - Access FSM state encoding.
//   - Reset values for the architectural registers.
//   - is_dev_addr(): returns 1 when an address hits a device register.
package lc3_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic [15:0] MAR_RST  = 16'h0000;
    localparam logic [15:0] MDR_RST  = 16'h0000;
    localparam logic [15:0] KBSR_RST = 16'h0000;
    localparam logic [15:0] DSR_RST  = 16'h8000;
    localparam logic [15:0] MCR_RST  = 16'h8000;

    function automatic logic is_dev_addr(input logic [15:0] a);
        return (a == KBSR_ADDR) || (a == KBDR_ADDR) || (a == DSR_ADDR) ||
               (a == DDR_ADDR)  || (a == MCR_ADDR);
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU-side memory control handshake of the memory controller.
//   mem_ld_mar   : load MAR from the shared bus
//   mem_ld_mdr   : load MDR (from bus when idle, from memory/device on DONE)
//   mem_gate_mdr : drive MDR onto the shared bus
//   mem_mio_en   : request a memory access
//   mem_rw       : 1 = write, 0 = read
//   mem_rdy      : access complete (one cycle)
// Modports: master = CPU side, slave = controller side.
interface mem_ctrl_if;
    logic mem_ld_mar;
    logic mem_ld_mdr;
    logic mem_gate_mdr;
    logic mem_mio_en;
    logic mem_rw;
    logic mem_rdy;

    modport master (
        output mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw,
        input  mem_rdy
    );

    modport slave (
        input  mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw,
        output mem_rdy
    );
endinterface

// File: rtl/mem_mmio_regs.sv
// Memory-mapped device registers: keyboard (KBSR/KBDR), display (DSR/DDR)
// and machine control (MCR). Decode and register logic exist only when
// MEM_CTRL_MMIO_EN is defined; otherwise nothing decodes as a device,
// disp_valid/irqs are 0 and run is 1.
// Ports:
//   clk, arst_n           : clock, asynchronous active-low reset
//   addr, wdata           : latched access address, write data (MDR)
//   wr, rd                : write strobe / read-with-load strobe (DONE cycle)
//   kbd_valid, kbd_data   : keyboard byte arrival
//   disp_rdy              : display ready for next byte
//   dev_sel, rdata        : address hits a device register, its read value
//   disp_valid, disp_data : one-cycle byte output to the display
//   kbd_irq, disp_irq     : registered interrupt requests
//   run                   : MCR[15]
module mem_mmio_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        wr,
    input  logic        rd,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    input  logic        disp_rdy,
    output logic        dev_sel,
    output logic [15:0] rdata,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    output logic        kbd_irq,
    output logic        disp_irq,
    output logic        run
);
`ifdef MEM_CTRL_MMIO_EN
    logic       kb_rdy_q, kb_ie_q, ds_rdy_q, ds_ie_q, run_q;
    logic       kb_rdy_d, kb_ie_d, ds_rdy_d, ds_ie_d, run_d;
    logic [7:0] kbdr_q, ddr_q;
    logic       disp_valid_q, kbd_irq_q, disp_irq_q;
    logic       wr_kbsr, wr_dsr, wr_ddr, wr_mcr, rd_kbdr;

    assign dev_sel = is_dev_addr(addr);
    assign wr_kbsr = wr && (addr == KBSR_ADDR);
    assign wr_dsr  = wr && (addr == DSR_ADDR);
    assign wr_ddr  = wr && (addr == DDR_ADDR);
    assign wr_mcr  = wr && (addr == MCR_ADDR);
    assign rd_kbdr = rd && (addr == KBDR_ADDR);

    always_comb begin
        rdata = '0;
        case (addr)
            KBSR_ADDR: rdata = {kb_rdy_q, kb_ie_q, 14'h0000};
            KBDR_ADDR: rdata = {8'h00, kbdr_q};
            DSR_ADDR:  rdata = {ds_rdy_q, ds_ie_q, 14'h0000};
            DDR_ADDR:  rdata = {8'h00, ddr_q};
            MCR_ADDR:  rdata = {run_q, 15'h0000};
            default:   rdata = '0;
        endcase
    end

    // Later assignments win: a new key beats the KBDR-read clear, and a DDR
    // write beats a same-cycle disp_rdy.
    always_comb begin
        kb_rdy_d = kb_rdy_q;
        if (rd_kbdr)   kb_rdy_d = 1'b0;
        if (kbd_valid) kb_rdy_d = 1'b1;
        kb_ie_d  = wr_kbsr ? wdata[14] : kb_ie_q;
        ds_rdy_d = ds_rdy_q;
        if (disp_rdy)  ds_rdy_d = 1'b1;
        if (wr_ddr)    ds_rdy_d = 1'b0;
        ds_ie_d  = wr_dsr ? wdata[14] : ds_ie_q;
        run_d    = wr_mcr ? wdata[15] : run_q;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            kb_rdy_q     <= KBSR_RST[15];
            kb_ie_q      <= KBSR_RST[14];
            ds_rdy_q     <= DSR_RST[15];
            ds_ie_q      <= DSR_RST[14];
            run_q        <= MCR_RST[15];
            kbdr_q       <= '0;
            ddr_q        <= '0;
            disp_valid_q <= 1'b0;
            kbd_irq_q    <= 1'b0;
            disp_irq_q   <= 1'b0;
        end else begin
            kb_rdy_q     <= kb_rdy_d;
            kb_ie_q      <= kb_ie_d;
            ds_rdy_q     <= ds_rdy_d;
            ds_ie_q      <= ds_ie_d;
            run_q        <= run_d;
            if (kbd_valid) kbdr_q <= kbd_data;
            if (wr_ddr)    ddr_q  <= wdata[7:0];
            disp_valid_q <= wr_ddr;
            // irqs follow the status bits in the same cycle they change
            kbd_irq_q    <= kb_rdy_d & kb_ie_d;
            disp_irq_q   <= ds_rdy_d & ds_ie_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = ddr_q;
    assign kbd_irq    = kbd_irq_q;
    assign disp_irq   = disp_irq_q;
    assign run        = run_q;
`else
    logic unused_mmio;
    assign unused_mmio = ^{clk, arst_n, addr, wdata, wr, rd, kbd_valid, kbd_data, disp_rdy};
    assign dev_sel     = 1'b0;
    assign rdata       = '0;
    assign disp_valid  = 1'b0;
    assign disp_data   = '0;
    assign kbd_irq     = 1'b0;
    assign disp_irq    = 1'b0;
    assign run         = 1'b1;
`endif
endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: MAR/MDR on a shared tri-state CPU bus, fixed-latency
// external memory access FSM, optional memory-mapped devices
// (compiled in with MEM_CTRL_MMIO_EN).
// Ports:
//   clk, arst_n          : clock (rising), asynchronous active-low reset
//   cpu                  : CPU control handshake (mem_ctrl_if.slave)
//   bus                  : 16-bit shared bus, driven with MDR under mem_gate_mdr
//   ext_addr, ext_wdata  : latched address, MDR
//   ext_rdata            : external read data, sampled on the DONE edge
//   ext_we               : one-cycle external write strobe
//   kbd_*, disp_*, run   : device side, see mem_mmio_regs
// Parameter MEM_LATENCY (1..15): cycles from access start to mem_rdy.
module mem_ctrl
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    mem_ctrl_if.slave   cpu,
    inout  wire  [15:0] bus,
    output logic [15:0] ext_addr,
    output logic [15:0] ext_wdata,
    input  logic [15:0] ext_rdata,
    output logic        ext_we,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    input  logic        disp_rdy,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    output logic        kbd_irq,
    output logic        disp_irq,
    output logic        run
);
    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mdr_q, acc_addr_q;
    logic        acc_rw_q, mem_rdy_q, ext_we_q;
    logic        start, in_done, dev_sel, dev_wr, dev_rd;
    logic [15:0] dev_rdata;

    assign start   = (state_q == ST_IDLE) && cpu.mem_mio_en;
    assign in_done = (state_q == ST_DONE);
    assign dev_wr  = in_done && acc_rw_q;
    assign dev_rd  = in_done && !acc_rw_q && cpu.mem_ld_mdr;

    // Counter is loaded with LATENCY-1 on start and DONE is entered on the
    // BUSY edge that finds it at zero, i.e. exactly MEM_LATENCY edges later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu.mem_mio_en) begin
                    state_d = ST_BUSY;
                    cnt_d   = LAT_M1;
                end
            end
            ST_BUSY: begin
                if (!cpu.mem_mio_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mar_q      <= MAR_RST;
            mdr_q      <= MDR_RST;
            acc_addr_q <= MAR_RST;
            acc_rw_q   <= 1'b0;
            mem_rdy_q  <= 1'b0;
            ext_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_rdy_q <= (state_d == ST_DONE);
            ext_we_q  <= (state_d == ST_DONE) && acc_rw_q && !dev_sel;
            if (cpu.mem_ld_mar) mar_q <= bus;
            if (start) begin
                acc_addr_q <= mar_q;
                acc_rw_q   <= cpu.mem_rw;
            end
            // A completing read owns MDR over a same-edge bus load.
            if (dev_rd) begin
                mdr_q <= dev_sel ? dev_rdata : ext_rdata;
            end else if (cpu.mem_ld_mdr && !cpu.mem_mio_en) begin
                mdr_q <= bus;
            end
        end
    end

    assign bus         = (cpu.mem_gate_mdr && arst_n) ? mdr_q : 'z;
    assign cpu.mem_rdy = mem_rdy_q;
    assign ext_addr    = acc_addr_q;
    assign ext_wdata   = mdr_q;
    assign ext_we      = ext_we_q;

    mem_mmio_regs u_mmio (
        .clk        (clk),
        .arst_n     (arst_n),
        .addr       (acc_addr_q),
        .wdata      (mdr_q),
        .wr         (dev_wr),
        .rd         (dev_rd),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_rdy   (disp_rdy),
        .dev_sel    (dev_sel),
        .rdata      (dev_rdata),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .kbd_irq    (kbd_irq),
        .disp_irq   (disp_irq),
        .run        (run)
    );
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// accesses checked against a transaction-level model of memory and devices.
// Device checks follow MEM_CTRL_MMIO_EN.
module tb_mem_ctrl;
    localparam int unsigned LAT = 4;
`ifdef MEM_CTRL_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst_n;
    wire  [15:0] bus;
    logic [15:0] tb_bus;
    logic        tb_drv;
    logic [15:0] ext_addr, ext_wdata, ext_rdata;
    logic        ext_we;
    logic        kbd_valid, disp_rdy, disp_valid, kbd_irq, disp_irq, run;
    logic [7:0]  kbd_data, disp_data;

    assign bus = tb_drv ? tb_bus : 'z;

    mem_ctrl_if cpu ();

    mem_ctrl #(.MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .cpu        (cpu),
        .bus        (bus),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .ext_we     (ext_we),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_rdy   (disp_rdy),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .kbd_irq    (kbd_irq),
        .disp_irq   (disp_irq),
        .run        (run)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int we_seen = 0;
    int rdy_seen = 0;
    int dv_seen = 0;

    always @(negedge clk) begin
        if (ext_we === 1'b1)      we_seen++;
        if (cpu.mem_rdy === 1'b1) rdy_seen++;
        if (disp_valid === 1'b1)  dv_seen++;
    end

    // Reference model of device state.
    logic       m_kb_rdy, m_kb_ie, m_ds_rdy, m_ds_ie, m_run;
    logic [7:0] m_kbdr, m_ddr;
    logic [15:0] dev_list [5];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_kb_rdy = 1'b0; m_kb_ie = 1'b0;
        m_ds_rdy = 1'b1; m_ds_ie = 1'b0;
        m_run = 1'b1; m_kbdr = 8'h00; m_ddr = 8'h00;
    endtask

    function automatic logic m_is_dev(input logic [15:0] a);
        return MMIO && (a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 ||
                        a == 16'hFE06 || a == 16'hFFFE);
    endfunction

    task automatic set_mdr(input logic [15:0] v);
        tb_drv = 1'b1; tb_bus = v; cpu.mem_ld_mdr = 1'b1;
        tick();
        cpu.mem_ld_mdr = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic set_mar(input logic [15:0] v);
        tb_drv = 1'b1; tb_bus = v; cpu.mem_ld_mar = 1'b1;
        tick();
        cpu.mem_ld_mar = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic wait_rdy(output int k);
        k = 0;
        while (cpu.mem_rdy !== 1'b1 && k < 4 * LAT + 8) begin
            tick();
            k++;
        end
    endtask

    task automatic kbd_event(input logic [7:0] b);
        kbd_valid = 1'b1; kbd_data = b;
        tick();
        kbd_valid = 1'b0;
        m_kb_rdy = 1'b1; m_kbdr = b;
        check("kbd_irq_evt", kbd_irq, m_kb_rdy & m_kb_ie & MMIO);
    endtask

    task automatic disp_pulse();
        disp_rdy = 1'b1;
        tick();
        disp_rdy = 1'b0;
        m_ds_rdy = 1'b1;
        check("disp_irq_evt", disp_irq, m_ds_rdy & m_ds_ie & MMIO);
    endtask

    task automatic check_reset_vals();
        check("rst_rdy", cpu.mem_rdy, 0);
        check("rst_we", ext_we, 0);
        check("rst_addr", ext_addr, 16'h0000);
        check("rst_mdr", ext_wdata, 16'h0000);
        check("rst_dv", disp_valid, 0);
        check("rst_kirq", kbd_irq, 0);
        check("rst_dirq", disp_irq, 0);
        check("rst_run", run, 1);
    endtask

    // One complete access as a CPU would run it; MAR and rw are disturbed
    // while the access is in flight, which must not affect it.
    task automatic do_access(input logic [15:0] addr, input logic rw, input logic [15:0] wdata,
                             input logic [15:0] rdata, input logic kbd_evt, input logic [7:0] kbd_byte);
        int k, we0, dv0;
        logic dev;
        logic [15:0] exp_rd;
        dev = m_is_dev(addr);
        exp_rd = rdata;
        set_mdr(wdata);
        set_mar(addr);
        ext_rdata = rdata; cpu.mem_rw = rw; cpu.mem_mio_en = 1'b1;
        we0 = we_seen; dv0 = dv_seen;
        tick();
        tb_drv = 1'b1; tb_bus = 16'($urandom); cpu.mem_ld_mar = 1'b1; cpu.mem_rw = ~rw;
        wait_rdy(k);
        cpu.mem_ld_mar = 1'b0; tb_drv = 1'b0;
        check("rdy_latency", k, LAT);
        check("acc_addr", ext_addr, addr);
        if (rw) check("acc_wdata", ext_wdata, wdata);
        if (!rw) cpu.mem_ld_mdr = 1'b1;
        cpu.mem_mio_en = 1'b0;
        if (kbd_evt) begin
            kbd_valid = 1'b1; kbd_data = kbd_byte;
        end
        tick();
        cpu.mem_ld_mdr = 1'b0; kbd_valid = 1'b0;
        // model update for the DONE edge
        if (dev && !rw) begin
            case (addr)
                16'hFE00: exp_rd = {m_kb_rdy, m_kb_ie, 14'h0000};
                16'hFE02: begin exp_rd = {8'h00, m_kbdr}; m_kb_rdy = 1'b0; end
                16'hFE04: exp_rd = {m_ds_rdy, m_ds_ie, 14'h0000};
                16'hFE06: exp_rd = {8'h00, m_ddr};
                default:  exp_rd = {m_run, 15'h0000};
            endcase
        end
        if (dev && rw) begin
            case (addr)
                16'hFE00: m_kb_ie = wdata[14];
                16'hFE04: m_ds_ie = wdata[14];
                16'hFE06: begin m_ddr = wdata[7:0]; m_ds_rdy = 1'b0; end
                16'hFFFE: m_run = wdata[15];
                default: ;
            endcase
        end
        if (kbd_evt) begin
            m_kb_rdy = 1'b1; m_kbdr = kbd_byte;
        end
        check("rdy_single", cpu.mem_rdy, 0);
        check("we_count", we_seen - we0, (rw && !dev) ? 1 : 0);
        if (!rw) begin
            cpu.mem_gate_mdr = 1'b1;
            #1;
            check("rd_data", bus, exp_rd);
            cpu.mem_gate_mdr = 1'b0;
        end
        tick();
        check("dv_count", dv_seen - dv0, (dev && rw && addr == 16'hFE06) ? 1 : 0);
        check("disp_data", disp_data, m_ddr);
        check("kbd_irq", kbd_irq, m_kb_rdy & m_kb_ie);
        check("disp_irq", disp_irq, m_ds_rdy & m_ds_ie & MMIO);
        check("run", run, m_run);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, we0, r0;
        logic [15:0] a;
        dev_list[0] = 16'hFE00; dev_list[1] = 16'hFE02; dev_list[2] = 16'hFE04;
        dev_list[3] = 16'hFE06; dev_list[4] = 16'hFFFE;
        arst_n = 1'b0; tb_drv = 1'b0; tb_bus = '0;
        cpu.mem_ld_mar = 1'b0; cpu.mem_ld_mdr = 1'b0; cpu.mem_gate_mdr = 1'b0;
        cpu.mem_mio_en = 1'b0; cpu.mem_rw = 1'b0;
        ext_rdata = '0; kbd_valid = 1'b0; kbd_data = '0; disp_rdy = 1'b0;
        m_reset();
        #2;
        check_reset_vals();
        tick(); tick();
        arst_n = 1'b1;
        tick();

        // basic read and write
        do_access(16'h3000, 1'b0, 16'h0000, 16'h1234, 1'b0, 8'h00);
        tb_drv = 1'b1; tb_bus = 16'hEDCB; #1;
        check("bus_hiz", bus, 16'hEDCB);
        tb_drv = 1'b0;
        do_access(16'h4000, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 8'h00);

        // mio_en held high through DONE restarts after one IDLE cycle
        set_mar(16'h5000);
        ext_rdata = 16'h0F0F; cpu.mem_rw = 1'b0; cpu.mem_mio_en = 1'b1;
        tick();
        wait_rdy(k);
        check("b2b_first", k, LAT);
        tick();
        wait_rdy(k);
        check("b2b_gap", k + 1, LAT + 2);
        cpu.mem_mio_en = 1'b0; cpu.mem_ld_mdr = 1'b1;
        tick();
        cpu.mem_ld_mdr = 1'b0; cpu.mem_gate_mdr = 1'b1; #1;
        check("b2b_mdr", bus, 16'h0F0F);
        cpu.mem_gate_mdr = 1'b0;
        tick();

        // abort: mio_en low at the T+2 edge
        set_mdr(16'h1111); set_mar(16'h7000);
        we0 = we_seen; r0 = rdy_seen;
        cpu.mem_rw = 1'b1; cpu.mem_mio_en = 1'b1;
        tick(); tick();
        cpu.mem_mio_en = 1'b0;
        tick();
        repeat (2 * LAT) tick();
        check("abort_rdy", rdy_seen - r0, 0);
        check("abort_we", we_seen - we0, 0);

        // asynchronous reset in the middle of a write
        set_mdr(16'hA5A5); set_mar(16'h6000);
        we0 = we_seen; r0 = rdy_seen;
        cpu.mem_rw = 1'b1; cpu.mem_mio_en = 1'b1;
        tick(); tick(); tick();
        arst_n = 1'b0; cpu.mem_mio_en = 1'b0;
        #1;
        check_reset_vals();
        tick(); tick();
        arst_n = 1'b1;
        m_reset();
        repeat (2 * LAT) tick();
        check("rst_abort_we", we_seen - we0, 0);
        check("rst_abort_rdy", rdy_seen - r0, 0);
        do_access(16'h6000, 1'b1, 16'h5A5A, 16'h0000, 1'b0, 8'h00);

`ifdef MEM_CTRL_MMIO_EN
        // keyboard
        do_access(16'hFE00, 1'b1, 16'h4000, 16'h0000, 1'b0, 8'h00);
        kbd_event(8'h41);
        check("kbd_irq_on", kbd_irq, 1);
        do_access(16'hFE02, 1'b0, 16'h0000, 16'hDEAD, 1'b0, 8'h00);
        check("kbd_irq_clr", kbd_irq, 0);
        kbd_event(8'h42);
        do_access(16'hFE02, 1'b0, 16'h0000, 16'hDEAD, 1'b1, 8'h43);
        check("kbd_race_irq", kbd_irq, 1);
        do_access(16'hFE00, 1'b0, 16'h0000, 16'hDEAD, 1'b0, 8'h00);
        do_access(16'hFE02, 1'b0, 16'h0000, 16'hDEAD, 1'b0, 8'h00);
        // display
        do_access(16'hFE06, 1'b1, 16'h0058, 16'h0000, 1'b0, 8'h00);
        check("ddr_byte", disp_data, 8'h58);
        do_access(16'hFE04, 1'b0, 16'h0000, 16'hDEAD, 1'b0, 8'h00);
        disp_pulse();
        do_access(16'hFE04, 1'b0, 16'h0000, 16'hDEAD, 1'b0, 8'h00);
`else
        // without devices the display address is plain external memory
        do_access(16'hFE06, 1'b1, 16'h0058, 16'h0000, 1'b0, 8'h00);
        check("ext_ddr_dv", disp_valid, 0);
        do_access(16'hFFFE, 1'b0, 16'h0000, 16'h7E57, 1'b0, 8'h00);
`endif

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            a = 16'($urandom);
            if (MMIO && $urandom_range(0, 1) == 1) a = dev_list[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) == 0) kbd_event(8'($urandom));
            if ($urandom_range(0, 3) == 0) disp_pulse();
            do_access(a, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 4) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
